// File: rtl/loadable_modn_counter.sv
// Loadable modulo-N up/down counter with count enable, cascade-friendly
// terminal count, registered wrap pulse and out-of-range load flag.
// Count stays within 0..MODULUS-1 for any input sequence after reset.
module loadable_modn_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // Reject moduli that cannot be represented or make no sense as a range.
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("loadable_modn_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_load_err;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_load_err_nxt;
    logic             w_data_ok;
    logic             w_at_max;
    logic             w_at_min;

    assign w_data_ok = ({1'b0, data} < MOD_EXT);
    assign w_at_max  = (r_count == MAX_VAL);
    assign w_at_min  = (r_count == '0);

    // Next-state selection: load beats count enable, otherwise hold.
    always_comb begin
        w_count_nxt    = r_count;
        w_wrap_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        if (load) begin
            w_count_nxt    = w_data_ok ? data : '0;
            w_load_err_nxt = ~w_data_ok;
        end else if (en) begin
            if (up_dn) begin
                // Explicit compare keeps wrap correct even when MODULUS == 2**WIDTH.
                w_count_nxt = w_at_max ? '0 : r_count + 1'b1;
                w_wrap_nxt  = w_at_max;
            end else begin
                w_count_nxt = w_at_min ? MAX_VAL : r_count - 1'b1;
                w_wrap_nxt  = w_at_min;
            end
        end
    end

    // State register; reset also cancels any pending wrap or load_err pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_wrap     <= w_wrap_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Terminal count is combinational so a downstream en can be fed directly.
    assign tc       = en & ~load & ((up_dn & w_at_max) | (~up_dn & w_at_min));
    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_loadable_modn_counter.sv
// Bench for loadable_modn_counter: a MODULUS=12 and a MODULUS=16 instance share
// stimulus and are compared against an arithmetic reference model; a separate
// 12 x 5 pair checks cascading through tc.
module tb_loadable_modn_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, load = 1'b0, up_dn = 1'b1;
    logic [3:0] data = 4'd0;

    logic [3:0] cnt12, cnt16;
    logic       tc12, tc16, wrap12, wrap16, err12, err16;

    logic       c_en = 1'b0;
    logic       c_zero = 1'b0;
    logic [3:0] c_zdata = 4'd0;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;

    int n_cmp = 0;
    int n_err = 0;

    int m_mod [2] = '{12, 16};
    int m_c   [2];
    bit m_w   [2];
    bit m_e   [2];

    always #5 clk = ~clk;

    loadable_modn_counter #(.WIDTH(4), .MODULUS(12)) u_m12 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up_dn(up_dn), .data(data),
        .count(cnt12), .tc(tc12), .wrap(wrap12), .load_err(err12));

    loadable_modn_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up_dn(up_dn), .data(data),
        .count(cnt16), .tc(tc16), .wrap(wrap16), .load_err(err16));

    loadable_modn_counter #(.WIDTH(4), .MODULUS(12)) u_lo (
        .clk(clk), .rst(rst), .en(c_en), .load(c_zero), .up_dn(1'b1), .data(c_zdata),
        .count(lo_cnt), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_err));

    loadable_modn_counter #(.WIDTH(4), .MODULUS(5)) u_hi (
        .clk(clk), .rst(rst), .en(lo_tc), .load(c_zero), .up_dn(1'b1), .data(c_zdata),
        .count(hi_cnt), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_err));

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_tc(input int i, input bit e, input bit l, input bit u);
        return e && !l && ((u && m_c[i] == m_mod[i] - 1) || (!u && m_c[i] == 0));
    endfunction

    task automatic model_step(input int i, input bit e, input bit l, input bit u, input int d);
        if (l) begin
            m_e[i] = (d >= m_mod[i]);
            m_c[i] = m_e[i] ? 0 : d;
            m_w[i] = 1'b0;
        end else if (e) begin
            m_e[i] = 1'b0;
            if (u) begin
                m_w[i] = (m_c[i] == m_mod[i] - 1);
                m_c[i] = (m_c[i] + 1) % m_mod[i];
            end else begin
                m_w[i] = (m_c[i] == 0);
                m_c[i] = (m_c[i] + m_mod[i] - 1) % m_mod[i];
            end
        end else begin
            m_w[i] = 1'b0;
            m_e[i] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_c[i] = 0; m_w[i] = 1'b0; m_e[i] = 1'b0;
        end
    endtask

    task automatic check_model_outputs();
        chk("count_m12", cnt12, m_c[0]);
        chk("wrap_m12", wrap12, m_w[0]);
        chk("err_m12", err12, m_e[0]);
        chk("count_m16", cnt16, m_c[1]);
        chk("wrap_m16", wrap16, m_w[1]);
        chk("err_m16", err16, m_e[1]);
    endtask

    // Called just after an edge; applies inputs, checks tc, clocks, checks state.
    task automatic step(input bit e, input bit l, input bit u, input logic [3:0] d);
        en = e; load = l; up_dn = u; data = d;
        #1;
        chk("tc_m12", tc12, model_tc(0, e, l, u));
        chk("tc_m16", tc16, model_tc(1, e, l, u));
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, e, l, u, int'(d));
        #1;
        check_model_outputs();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        model_reset();
        #1;
        check_model_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit       e, l, u;
        bit [3:0] d;
        bit       x_tc;
        int       x_cnt;
        bit       x_wrap, x_err;
    } vec_t;

    vec_t vecs [18];

    initial begin
        vecs[0]  = '{1, 1, 1, 4'd5,  0, 5,  0, 0};
        vecs[1]  = '{0, 1, 0, 4'd13, 0, 0,  0, 1};
        vecs[2]  = '{0, 0, 0, 4'd0,  0, 0,  0, 0};
        vecs[3]  = '{1, 1, 1, 4'd11, 0, 11, 0, 0};
        vecs[4]  = '{1, 0, 1, 4'd0,  1, 0,  1, 0};
        vecs[5]  = '{1, 0, 0, 4'd0,  1, 11, 1, 0};
        vecs[6]  = '{0, 1, 1, 4'd2,  0, 2,  0, 0};
        vecs[7]  = '{1, 0, 0, 4'd0,  0, 1,  0, 0};
        vecs[8]  = '{1, 0, 0, 4'd0,  0, 0,  0, 0};
        vecs[9]  = '{1, 0, 0, 4'd0,  1, 11, 1, 0};
        vecs[10] = '{1, 0, 0, 4'd0,  0, 10, 0, 0};
        vecs[11] = '{1, 0, 1, 4'd0,  0, 11, 0, 0};
        vecs[12] = '{1, 0, 1, 4'd0,  1, 0,  1, 0};
        vecs[13] = '{1, 0, 0, 4'd0,  1, 11, 1, 0};
        vecs[14] = '{0, 0, 1, 4'd0,  0, 11, 0, 0};
        vecs[15] = '{1, 1, 1, 4'd12, 0, 0,  0, 1};
        vecs[16] = '{1, 1, 0, 4'd15, 0, 0,  0, 1};
        vecs[17] = '{1, 0, 1, 4'd0,  0, 1,  0, 0};

        // Reset, then idle with en=0 for ten cycles.
        model_reset();
        #2;
        check_model_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1, 4'd0);
            chk("idle_hold", cnt12, 0);
        end

        // Table of directed vectors on the MODULUS=12 instance.
        foreach (vecs[i]) begin
            en = vecs[i].e; load = vecs[i].l; up_dn = vecs[i].u; data = vecs[i].d;
            #1;
            chk($sformatf("vec%0d_tc", i), tc12, vecs[i].x_tc);
            @(posedge clk);
            for (int j = 0; j < 2; j++) model_step(j, vecs[i].e, vecs[i].l, vecs[i].u, int'(vecs[i].d));
            #1;
            chk($sformatf("vec%0d_count", i), cnt12, vecs[i].x_cnt);
            chk($sformatf("vec%0d_wrap", i), wrap12, vecs[i].x_wrap);
            chk($sformatf("vec%0d_err", i), err12, vecs[i].x_err);
            chk($sformatf("vec%0d_m16", i), cnt16, m_c[1]);
        end

        // Asynchronous reset mid-cycle with count=7.
        step(0, 1, 1, 4'd7);
        chk("pre_reset_count", cnt12, 7);
        en = 1'b0; load = 1'b0;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_reset_count", cnt12, 0);
        check_model_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full up count 0..11,0 with exact tc and wrap placement.
        for (int k = 0; k < 12; k++) begin
            step(1, 0, 1, 4'd0);
            chk("up_seq_count", cnt12, (k + 1) % 12);
            chk("up_seq_wrap", wrap12, (k == 11) ? 1 : 0);
        end

        // Reset cancels a pending wrap pulse.
        step(0, 1, 1, 4'd11);
        step(1, 0, 1, 4'd0);
        chk("wrap_before_cancel", wrap12, 1);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("wrap_cancelled", wrap12, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset cancels a pending load_err pulse.
        step(0, 1, 0, 4'd14);
        chk("err_before_cancel", err12, 1);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("err_cancelled", err12, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full-range modulus: load 15 is legal, rollover 15 -> 0 wraps.
        step(0, 1, 1, 4'd15);
        chk("m16_load15_err", err16, 0);
        chk("m16_load15_cnt", cnt16, 15);
        step(1, 0, 1, 4'd0);
        chk("m16_roll_cnt", cnt16, 0);
        chk("m16_roll_wrap", wrap16, 1);
        step(1, 0, 0, 4'd0);
        chk("m16_down_cnt", cnt16, 15);
        chk("m16_down_wrap", wrap16, 1);

        // Randomised traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        // Cascade: high counter advances once per twelve low-counter steps.
        en = 1'b0; load = 1'b0;
        rst = 1'b0;
        #1;
        chk("casc_reset_lo", lo_cnt, 0);
        chk("casc_reset_hi", hi_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        c_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            chk("casc_lo", lo_cnt, k % 12);
            chk("casc_hi", hi_cnt, (k / 12) % 5);
        end
        chk("casc_hi_wrap", hi_wrap, 1);
        c_en = 1'b0;
        @(posedge clk);
        #1;
        chk("casc_hold_hi", hi_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/loadable_modn_counter.md
Name: loadable_modn_counter

Overview:
Parametrised loadable modulo-N up/down counter, the successor to the team's fixed mod-12 loadable counter. It generalises width and modulus and adds count enable, direction control, a terminal-count output for cascading, a registered wrap pulse and load-range checking. Intended for timing and sequence generation, with multiple instances chainable via tc into en.

Parameters:
WIDTH, 4, count and data width in bits
MODULUS, 12, counting range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH (elaboration error otherwise)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  count enable
load  input  1  synchronous parallel load strobe
up_dn  input  1  direction: 1 = count up, 0 = count down
data  input  WIDTH  parallel load value
count  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational
wrap  output  1  registered one-cycle pulse after a wrap
load_err  output  1  registered one-cycle pulse after an out-of-range load

Behaviour:
- Reset: rst low forces count=0, wrap=0, load_err=0 immediately, independent of clk. Release is synchronous to the next rising edge, with the first update on the first edge while rst is high.
- Priority per edge: load > en > hold.
- Load: with data < MODULUS, count<=data, wrap<=0, load_err<=0. With data >= MODULUS, count<=0 and load_err<=1 for exactly one cycle. Load ignores en and up_dn. X on data while load=0 has no effect.
- Count up (en=1, up_dn=1): count==MODULUS-1 gives count<=0 and wrap<=1; otherwise count<=count+1 and wrap<=0.
- Count down (en=1, up_dn=0): count==0 gives count<=MODULUS-1 and wrap<=1; otherwise count<=count-1 and wrap<=0.
- Hold (en=0, load=0): count unchanged, wrap<=0, load_err<=0.
- tc = en & ~load & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)). tc is high in the same cycle whose next edge wraps, so a downstream counter's en can be driven directly from tc.
- Arithmetic is modulo MODULUS, never modulo 2**WIDTH. Count never takes a value >= MODULUS after reset. When MODULUS==2**WIDTH the natural rollover must still assert wrap.
- Direction change takes effect on the next edge with no extra latency. Toggling up_dn at a boundary follows the rules above for the sampled direction.
- Simultaneous load and en: load wins, no count step and no wrap pulse.
- Reset asserted mid-count or mid-load: outputs clear immediately, and any pending wrap or load_err pulse is cancelled.
- Latency: one clock from load/en sampled to count update. wrap and load_err align with the updated count.

Test Plan:
- Reset and idle: assert rst=0 mid-cycle with count=7 -> count=0, wrap=0, load_err=0 before the next edge. With en=0 after release, count holds 0 for 10 cycles.
- Up count and wrap (WIDTH=4, MODULUS=12): en=1, up_dn=1 from 0 -> count 0..11,0. tc=1 only while count=11. wrap=1 for exactly the one cycle in which count=0 after 11.
- Down count and wrap: load 2, then en=1, up_dn=0 -> 2,1,0,11,10. tc=1 while count=0. wrap pulses when count becomes 11.
- Load priority and range: load=1, en=1, data=5 -> count=5, no wrap. Then load data=13 -> count=0 and load_err=1 for one cycle, then 0. Load data=11 -> count=11, tc=1 if en=1 and up_dn=1.
- Full-range modulus (WIDTH=4, MODULUS=16): count up from 15 -> 0 with wrap=1. Load 15 gives load_err=0.
- Cascade: two instances (MODULUS=12 and MODULUS=5), with the high counter's en driven by the low counter's tc -> the high counter increments once per 12 low-counter cycles, and the pair returns to 0,0 after 60 enabled cycles.
